queue_param_gen: RTL
====================

Name: queue_param_gen

Overview:
- Parametrised successor of the team's 8-bit single-bus queue.
- Stores words written from a shared bidirectional data bus (IOports) and returns them on the same bus.
- Configurable width, depth and ordering mode (FIFO or LIFO).
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Sits between a bus-sharing producer/consumer and the downstream datapath.

Parameters:
- N, 8, data width in bits of IOports and of each storage word.
- DEPTH, 1024, number of storage words; any value >= 2.
- MODE, 0, ordering: 0 = FIFO (first in, first out), 1 = LIFO (last in, first out).
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL.
- CW, $clog2(DEPTH+1), width of count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- IOports  inout  N  shared data bus: driven by the environment when ReadWrite=1, by this block when ReadWrite=0.
- en  input  1  operation enable; no push or pop when 0.
- ReadWrite  input  1  1 = write (push), 0 = read (pop).
- flush  input  1  synchronous clear of contents; has priority over en.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_empty  output  1  count <= AE_LEVEL.
- almost_full  output  1  count >= AF_LEVEL.
- count  output  CW  number of stored words.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-high.
  - On reset assertion, immediately: count=0, read/write pointers=0, data-out register=0, empty=1, full=0, almost_empty=1, almost_full=0 (for AF_LEVEL>0), overflow=0, underflow=0.
  - Storage array contents are not cleared.
  - Reset asserted mid-operation aborts any push/pop in that cycle.
- Bus drive:
  - IOports = data-out register when ReadWrite=0, else high-Z.
  - The drive is combinational on ReadWrite and independent of en.
- Push (en=1, ReadWrite=1, flush=0):
  - If not full: store IOports at the rising edge and count+1.
  - If full: storage and count unchanged; overflow set to 1.
- Pop (en=1, ReadWrite=0, flush=0):
  - If not empty: the selected word is loaded into the data-out register at the edge and count-1.
  - The popped word appears on IOports after that edge (1-cycle latency from the sampling edge).
  - If empty: data-out register holds its value; underflow set to 1.
- en=0: no state change except flush; data-out register holds.
- Push and pop are mutually exclusive by construction (a single ReadWrite line), so there is no simultaneous-event case.
- FIFO mode (MODE=0):
  - wr_ptr and rd_ptr each range 0..DEPTH-1.
  - Each advances by 1 on its operation and wraps from DEPTH-1 to 0 (explicit compare; DEPTH need not be a power of two).
- LIFO mode (MODE=1):
  - Push writes mem[count]; pop reads mem[count-1].
  - Pointers are unused and may be optimised away.
- Flush (flush=1 at an edge):
  - Sets count=0 and pointers=0, and clears overflow/underflow.
  - Data-out register holds its value.
  - Any push/pop that cycle is ignored.
- Status flags are combinational decodes of registered count, so they change in the same cycle as count.
- Error flags clear only on reset or flush.
- Count is width CW and never exceeds DEPTH or goes below 0.

Test Plan:
- N=8, DEPTH=8, MODE=0, AE_LEVEL=2, AF_LEVEL=6:
  - reset, then push 10,20,...,80 → count 1..8; almost_empty drops at count 3; almost_full rises at 6; full=1 at 8.
  - 9th push of 90 → overflow=1, count stays 8.
- Same configuration, then pop 8 times with ReadWrite=0 → IOports shows 10,20,...,80, each one cycle after its pop edge; empty=1 after the 8th pop.
  - 9th pop → underflow=1, IOports holds 80.
- FIFO wrap:
  - push 5 words, pop 3, push 6 → count=8, full=1.
  - 8 pops return 4th,5th then the 6 new words in order (pointer wrap 7→0 verified).
- MODE=1, DEPTH=8:
  - push 1,2,3,4, pop 2 → returns 4,3.
  - push 9, pop 3 → returns 9,2,1; empty=1.
- en gating: hold en=0 for 4 cycles during a push burst and a pop burst → count, pointers and IOports unchanged across those cycles.
- flush with count=5 and overflow=1 → next edge count=0, empty=1, overflow=0.
- Asynchronous reset asserted mid-cycle during a push → outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/queue_param_gen.sv
// Parametrised FIFO/LIFO queue on a shared bidirectional bus, with occupancy
// count, almost-full/almost-empty thresholds, sticky error flags and flush.
module queue_param_gen #(
  parameter int N        = 8,
  parameter int DEPTH    = 1024,
  parameter int MODE     = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  inout  wire  [N-1:0]  IOports,
  input  logic          en,
  input  logic          ReadWrite,
  input  logic          flush,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [N-1:0]  mem [DEPTH];
  logic [N-1:0]  data_out;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_idx, rd_idx;
  logic [CW-1:0] count_m1;
  logic          push_ok, pop_ok;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  // The bus turns around purely on ReadWrite, so a reader sees the last popped
  // word even while en is low.
  assign IOports = ReadWrite ? {N{1'bz}} : data_out;

  assign push_ok  = en &  ReadWrite & ~flush & ~full;
  assign pop_ok   = en & ~ReadWrite & ~flush & ~empty;
  assign count_m1 = count - CW'(1);

  // LIFO addresses straight from the occupancy; FIFO uses the ring pointers.
  assign wr_idx = (MODE == 1) ? count[PW-1:0]    : wr_ptr;
  assign rd_idx = (MODE == 1) ? count_m1[PW-1:0] : rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  // Storage is left uncleared by reset; stale words are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_idx] <= IOports;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (en) begin
      if (ReadWrite) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          count <= count + CW'(1);
          if (MODE == 0)
            wr_ptr <= next_ptr(wr_ptr);
        end
      end else begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          data_out <= mem[rd_idx];
          count    <= count_m1;
          if (MODE == 0)
            rd_ptr <= next_ptr(rd_ptr);
        end
      end
    end
  end

  // Pop qualification is folded into the register block above.
  logic unused_pop;
  assign unused_pop = pop_ok;

endmodule
